apb_xfer_sequencer: RTL and testbench

HCLK-domain controller that arbitrates between two APB transfer requesters and sequences the bridge's HCLK-side APB outputs (Pselx/Penable/Paddr/Pwrite/Pwdata) feeding the HCLK→PCLK synchronizers. Each APB phase is stretched over a programmable number of Hclk cycles so the 2-FF synchronized copies in the PCLK domain are stable for full PCLK periods. Read data returns through the PCLK→HCLK synchronizer and is captured into a single-cycle response.

---
 rtl/apb_xfer_sequencer.sv | 161 ++++++++++++++++
 tb/tb_apb_xfer_sequencer.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_xfer_sequencer.sv
// apb_xfer_sequencer: two-requester arbiter and HCLK-side APB phase sequencer.
// SETUP/ACCESS are stretched so synchronized PCLK-domain copies stay stable.
module apb_xfer_sequencer #(
  parameter int unsigned SETUP_HOLD  = 4,
  parameter int unsigned ACCESS_HOLD = 8
) (
  input  logic        Hclk,
  input  logic        Hreset,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic        req0_write,
  input  logic [31:0] req0_addr,
  input  logic [31:0] req0_wdata,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic        req1_write,
  input  logic [31:0] req1_addr,
  input  logic [31:0] req1_wdata,
  output logic        rsp_valid,
  output logic        rsp_id,
  output logic        rsp_err,
  output logic [31:0] rsp_rdata,
  output logic        busy,
  output logic [2:0]  Pselx_hclk,
  output logic        Penable_hclk,
  output logic        Pwrite_hclk,
  output logic [31:0] Paddr_hclk,
  output logic [31:0] Pwdata_hclk,
  input  logic [31:0] Prdata_hclk
);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    DONE
  } state_t;

  localparam logic [7:0] SETUP_INIT = 8'(SETUP_HOLD - 1);
  localparam logic [7:0] ACC_INIT   = 8'(ACCESS_HOLD - 1);

  state_t      state, state_nxt;
  logic [7:0]  cnt, cnt_nxt;
  logic [2:0]  sel_q, dec;
  logic [2:0]  psel_nxt;
  logic        pen_nxt, rv_nxt;
  logic        last_grant, id_q;
  logic        hs, hs_id;
  logic [31:0] hs_addr;
  logic        last_access;

  // Tie goes to whichever requester was not granted last.
  assign req0_ready = (state == IDLE) & req0_valid
                    & (~req1_valid | last_grant);
  assign req1_ready = (state == IDLE) & req1_valid
                    & (~req0_valid | ~last_grant);

  assign hs      = req0_ready | req1_ready;
  assign hs_id   = req1_ready;
  assign hs_addr = hs_id ? req1_addr : req0_addr;
  assign busy    = (state != IDLE);

  assign last_access = (state == ACCESS) && (cnt == 8'd0);

  always_comb begin
    dec = 3'b000;
    unique case (1'b1)
      hs_addr[31:26] == 6'h20: dec = 3'b001;
      hs_addr[31:26] == 6'h21: dec = 3'b010;
      hs_addr[31:26] == 6'h22: dec = 3'b100;
      default:                 dec = 3'b000;
    endcase
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    psel_nxt  = 3'b000;
    pen_nxt   = 1'b0;
    rv_nxt    = 1'b0;
    unique case (state)
      IDLE: begin
        if (hs) begin
          if (dec != 3'b000) begin
            state_nxt = SETUP;
            cnt_nxt   = SETUP_INIT;
            psel_nxt  = dec;
          end else begin
            state_nxt = DONE;
            rv_nxt    = 1'b1;
          end
        end
      end
      SETUP: begin
        psel_nxt = sel_q;
        if (cnt == 8'd0) begin
          state_nxt = ACCESS;
          cnt_nxt   = ACC_INIT;
          pen_nxt   = 1'b1;
        end else begin
          cnt_nxt = cnt - 8'd1;
        end
      end
      ACCESS: begin
        if (cnt == 8'd0) begin
          state_nxt = DONE;
          rv_nxt    = 1'b1;
        end else begin
          cnt_nxt  = cnt - 8'd1;
          psel_nxt = sel_q;
          pen_nxt  = 1'b1;
        end
      end
      DONE: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Hclk or posedge Hreset) begin
    if (Hreset) begin
      state        <= IDLE;
      cnt          <= '0;
      sel_q        <= '0;
      id_q         <= 1'b0;
      last_grant   <= 1'b1;
      Pselx_hclk   <= '0;
      Penable_hclk <= 1'b0;
      Pwrite_hclk  <= 1'b0;
      Paddr_hclk   <= '0;
      Pwdata_hclk  <= '0;
      rsp_valid    <= 1'b0;
      rsp_id       <= 1'b0;
      rsp_err      <= 1'b0;
      rsp_rdata    <= '0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      Pselx_hclk   <= psel_nxt;
      Penable_hclk <= pen_nxt;
      rsp_valid    <= rv_nxt;
      if (hs) begin
        last_grant  <= hs_id;
        id_q        <= hs_id;
        sel_q       <= dec;
        Paddr_hclk  <= hs_addr;
        Pwrite_hclk <= hs_id ? req1_write : req0_write;
        Pwdata_hclk <= hs_id ? req1_wdata : req0_wdata;
        if (dec == 3'b000) begin
          rsp_id    <= hs_id;
          rsp_err   <= 1'b1;
          rsp_rdata <= '0;
        end
      end
      if (last_access) begin
        rsp_id    <= id_q;
        rsp_err   <= 1'b0;
        rsp_rdata <= Pwrite_hclk ? 32'h0 : Prdata_hclk;
      end
    end
  end

endmodule

// File: tb/tb_apb_xfer_sequencer.sv
// tb_apb_xfer_sequencer: randomized + directed bench with a scoreboard.
// Expected responses come from a transfer-level timing/decoding model.
module tb_apb_xfer_sequencer;

  localparam int SH = 4;
  localparam int AH = 8;

  logic        Hclk = 1'b0;
  logic        Hreset = 1'b1;
  logic        req0_valid = 0, req1_valid = 0;
  logic        req0_write = 0, req1_write = 0;
  logic [31:0] req0_addr = '0, req1_addr = '0;
  logic [31:0] req0_wdata = '0, req1_wdata = '0;
  logic [31:0] Prdata_hclk = '0;
  logic        req0_ready, req1_ready;
  logic        rsp_valid, rsp_id, rsp_err, busy;
  logic [31:0] rsp_rdata, Paddr_hclk, Pwdata_hclk;
  logic [2:0]  Pselx_hclk;
  logic        Penable_hclk, Pwrite_hclk;

  logic        f_valid = 0, f_write = 0;
  logic [31:0] f_addr = '0, f_wdata = '0;
  logic        f_z1 = 0;
  logic [31:0] f_zero = '0;
  logic        f_ready, f_ready1, f_rv, f_rid, f_rerr, f_busy;
  logic        f_pen, f_pwr;
  logic [31:0] f_rdata, f_paddr, f_pwdata;
  logic [2:0]  f_psel;

  apb_xfer_sequencer #(.SETUP_HOLD(SH), .ACCESS_HOLD(AH)) dut (
    .Hclk(Hclk), .Hreset(Hreset),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_write(req0_write), .req0_addr(req0_addr),
    .req0_wdata(req0_wdata),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_write(req1_write), .req1_addr(req1_addr),
    .req1_wdata(req1_wdata),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_err(rsp_err),
    .rsp_rdata(rsp_rdata), .busy(busy),
    .Pselx_hclk(Pselx_hclk), .Penable_hclk(Penable_hclk),
    .Pwrite_hclk(Pwrite_hclk), .Paddr_hclk(Paddr_hclk),
    .Pwdata_hclk(Pwdata_hclk), .Prdata_hclk(Prdata_hclk)
  );

  apb_xfer_sequencer #(.SETUP_HOLD(1), .ACCESS_HOLD(1)) fast (
    .Hclk(Hclk), .Hreset(Hreset),
    .req0_valid(f_valid), .req0_ready(f_ready),
    .req0_write(f_write), .req0_addr(f_addr),
    .req0_wdata(f_wdata),
    .req1_valid(f_z1), .req1_ready(f_ready1),
    .req1_write(f_z1), .req1_addr(f_zero),
    .req1_wdata(f_zero),
    .rsp_valid(f_rv), .rsp_id(f_rid), .rsp_err(f_rerr),
    .rsp_rdata(f_rdata), .busy(f_busy),
    .Pselx_hclk(f_psel), .Penable_hclk(f_pen),
    .Pwrite_hclk(f_pwr), .Paddr_hclk(f_paddr),
    .Pwdata_hclk(f_pwdata), .Prdata_hclk(f_zero)
  );

  always #5 Hclk = ~Hclk;

  int cyc = 0;
  always @(posedge Hclk) cyc <= cyc + 1;

  typedef struct {
    bit          id;
    bit          err;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [2:0]  sel;
    int          hs;
    int          lat;
  } exp_t;

  exp_t        q[$];
  logic [31:0] plan[$];
  int          hs_log[$];
  bit          gid_log[$];
  int          n_chk = 0;
  int          n_pass = 0;
  bit          model_last = 1'b1;
  int          free_cyc = 0;

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)",
                  nm, got, exp, cyc);
  endtask

  function automatic logic [2:0] ref_sel(input logic [31:0] a);
    if (a >= 32'h8000_0000 && a <= 32'h83FF_FFFF) return 3'b001;
    if (a >= 32'h8400_0000 && a <= 32'h87FF_FFFF) return 3'b010;
    if (a >= 32'h8800_0000 && a <= 32'h8BFF_FFFF) return 3'b100;
    return 3'b000;
  endfunction

  // Handshake observer: arbitration model and scoreboard push.
  always @(negedge Hclk) begin
    exp_t        e;
    bit          exp_rdy, gid, eid;
    logic [31:0] prd;
    if (Hreset) begin
      q.delete();
      model_last = 1'b1;
      free_cyc   = 0;
    end else begin
      exp_rdy = (cyc >= free_cyc) && (req0_valid || req1_valid);
      chk("ready", 32'(req0_ready | req1_ready), 32'(exp_rdy));
      if ((req0_valid && req0_ready) || (req1_valid && req1_ready)) begin
        chk("one_grant", 32'(req0_ready & req1_ready), 32'h0);
        gid = req1_valid && req1_ready;
        eid = (req0_valid && req1_valid) ? !model_last : req1_valid;
        chk("grant_id", 32'(gid), 32'(eid));
        prd = (plan.size() != 0) ? plan.pop_front() : $urandom;
        Prdata_hclk = prd;
        e.id    = gid;
        e.wr    = gid ? req1_write : req0_write;
        e.addr  = gid ? req1_addr : req0_addr;
        e.wdata = gid ? req1_wdata : req0_wdata;
        e.sel   = ref_sel(e.addr);
        e.err   = (e.sel == 3'b000);
        e.rdata = (e.err || e.wr) ? 32'h0 : prd;
        e.lat   = e.err ? 1 : SH + AH + 1;
        e.hs    = cyc;
        q.push_back(e);
        hs_log.push_back(cyc);
        gid_log.push_back(gid);
        model_last = gid;
        free_cyc   = cyc + e.lat + 1;
      end
    end
  end

  // Response and bus monitor.
  always @(negedge Hclk) begin
    exp_t       e;
    int         k;
    logic [2:0] esel;
    bit         een;
    if (!Hreset) begin
      esel = 3'b000;
      een  = 1'b0;
      k    = 0;
      if (q.size() != 0) begin
        k = cyc - q[0].hs;
        if (!q[0].err && k >= 1 && k <= SH + AH) esel = q[0].sel;
        een = !q[0].err && k >= SH + 1 && k <= SH + AH;
        if (k >= 1) begin
          chk("paddr", Paddr_hclk, q[0].addr);
          chk("pwrite", 32'(Pwrite_hclk), 32'(q[0].wr));
          chk("pwdata", Pwdata_hclk, q[0].wdata);
        end
      end
      chk("pselx", 32'(Pselx_hclk), 32'(esel));
      chk("penable", 32'(Penable_hclk), 32'(een));
      if (rsp_valid) begin
        if (q.size() == 0) begin
          n_chk++;
          $display("FAIL unexpected_rsp: got rsp_valid=1 expected 0 (cycle %0d)",
                   cyc);
        end else begin
          e = q.pop_front();
          chk("rsp_latency", 32'(cyc - e.hs), 32'(e.lat));
          chk("rsp_id", 32'(rsp_id), 32'(e.id));
          chk("rsp_err", 32'(rsp_err), 32'(e.err));
          chk("rsp_rdata", rsp_rdata, e.rdata);
        end
      end else if (q.size() != 0 && cyc - q[0].hs > q[0].lat) begin
        n_chk++;
        $display("FAIL missing_rsp: got no rsp_valid expected one at cycle %0d",
                 q[0].hs + q[0].lat);
        void'(q.pop_front());
      end
    end
  end

  task automatic issue(input bit id, input bit w,
                       input logic [31:0] a, input logic [31:0] d);
    bit got;
    got = 1'b0;
    if (id) begin
      req1_write = w; req1_addr = a; req1_wdata = d; req1_valid = 1'b1;
    end else begin
      req0_write = w; req0_addr = a; req0_wdata = d; req0_valid = 1'b1;
    end
    for (int i = 0; i < 300; i++) begin
      @(negedge Hclk);
      if (id ? req1_ready : req0_ready) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      n_chk++;
      $display("FAIL handshake_timeout: got no ready expected ready (req%0d)", id);
    end
    @(posedge Hclk);
    #1;
    if (id) req1_valid = 1'b0;
    else    req0_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge Hclk);
      if (q.size() == 0 && !busy) begin
        ok = 1'b1;
        break;
      end
    end
    chk("idle_reached", 32'(ok), 32'h1);
    @(posedge Hclk);
    #1;
  endtask

  function automatic logic [31:0] rnd_addr();
    logic [31:0] a;
    logic [31:0] bnd [4];
    bnd = '{32'h7FFF_FFFF, 32'h83FF_FFFF, 32'h8BFF_FFFF, 32'h8C00_0000};
    case ($urandom_range(0, 4))
      0, 1, 2: a = 32'h8000_0000 + 32'h0400_0000 * $urandom_range(0, 2)
                 + ($urandom & 32'h03FF_FFFF);
      3: begin
        a = $urandom;
        if (a[31:26] inside {6'h20, 6'h21, 6'h22}) a[31] = 1'b0;
      end
      default: a = bnd[$urandom_range(0, 3)];
    endcase
    return a;
  endfunction

  task automatic rnd_driver(input bit id, input int n);
    int g;
    for (int i = 0; i < n; i++) begin
      g = $urandom_range(0, 3);
      repeat (g) @(posedge Hclk);
      #1;
      issue(id, 1'($urandom_range(0, 1)), rnd_addr(), $urandom);
    end
  endtask

  logic [2:0] fsel [3];
  bit         fen [3];
  bit         frv [3];

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion expected finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge Hclk);
    chk("rst_pselx", 32'(Pselx_hclk), 32'h0);
    chk("rst_penable", 32'(Penable_hclk), 32'h0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_paddr", Paddr_hclk, 32'h0);
    chk("rst_rdata", rsp_rdata, 32'h0);
    @(posedge Hclk);
    #1;
    Hreset = 1'b0;

    issue(0, 1'b1, 32'h8000_0010, 32'hDEAD_BEEF);
    wait_idle();
    plan.push_back(32'h1234_5678);
    issue(1, 1'b0, 32'h8400_0004, 32'h0);
    wait_idle();
    issue(0, 1'b0, 32'h9000_0000, 32'h0);
    wait_idle();

    // Reset lands at T7 of a read, while the bus is in ACCESS.
    issue(1, 1'b0, 32'h8800_0040, 32'h0);
    repeat (6) @(posedge Hclk);
    #1;
    Hreset = 1'b1;
    #1;
    chk("mid_rst_pselx", 32'(Pselx_hclk), 32'h0);
    chk("mid_rst_penable", 32'(Penable_hclk), 32'h0);
    chk("mid_rst_busy", 32'(busy), 32'h0);
    repeat (2) @(posedge Hclk);
    #1;
    Hreset = 1'b0;

    hs_log.delete();
    gid_log.delete();
    fork
      begin
        issue(0, 1'b1, 32'h8000_0100, 32'h0000_0A0A);
        issue(0, 1'b0, 32'h8800_0200, 32'h0);
      end
      begin
        issue(1, 1'b0, 32'h8400_0300, 32'h0);
        issue(1, 1'b1, 32'h8000_0400, 32'h0000_0B0B);
      end
    join
    wait_idle();
    chk("alt_count", 32'(gid_log.size()), 32'h4);
    for (int i = 0; i < gid_log.size(); i++)
      chk("alt_grant", 32'(gid_log[i]), 32'(i % 2));
    for (int i = 0; i + 1 < hs_log.size(); i++)
      chk("alt_spacing", 32'(hs_log[i+1] - hs_log[i]), 32'(SH + AH + 2));

    fork
      rnd_driver(0, 12);
      rnd_driver(1, 12);
    join
    wait_idle();

    fsel = '{3'b100, 3'b100, 3'b000};
    fen  = '{1'b0, 1'b1, 1'b0};
    frv  = '{1'b0, 1'b0, 1'b1};
    f_write = 1'b1;
    f_addr  = 32'h8800_0000;
    f_wdata = 32'h0000_5A5A;
    f_valid = 1'b1;
    begin
      bit got;
      got = 1'b0;
      for (int i = 0; i < 20; i++) begin
        @(negedge Hclk);
        if (f_ready) begin
          got = 1'b1;
          break;
        end
      end
      chk("fast_handshake", 32'(got), 32'h1);
    end
    @(posedge Hclk);
    #1;
    f_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge Hclk);
      chk("fast_pselx", 32'(f_psel), 32'(fsel[k]));
      chk("fast_penable", 32'(f_pen), 32'(fen[k]));
      chk("fast_rsp_valid", 32'(f_rv), 32'(frv[k]));
    end
    chk("fast_rsp_err", 32'(f_rerr), 32'h0);
    chk("fast_rsp_rdata", f_rdata, 32'h0);
    chk("fast_paddr", f_paddr, 32'h8800_0000);

    chk("queue_drained", 32'(q.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
